// File: rtl/hop_pkg.sv
// Shared definitions for the hop-chain benchmark family: the sequencer
// state type and the default timing constants every hopN design agrees on.
package hop_pkg;

  // Sequencer states, in the order a normal run visits them.
  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,  // global reset asserted or still being synchronized
    RELEASE  = 3'd1,  // dropping stage resets one by one
    IDLE     = 3'd2,  // chain out of reset, waiting for a launch
    WAIT     = 3'd3,  // token in flight, latency counter running
    DONE     = 3'd4   // result latched, waiting for a relaunch
  } hop_seq_state_t;

  // A five-flop chain returns the token five cycles after launch.
  localparam int HOP_EXP_LAT  = 5;
  // Cycles each stage sits out of reset before the next one follows.
  localparam int HOP_HOLD_CYC = 4;
  // Cycles after launch before the token is declared lost.
  localparam int HOP_TIMEOUT  = 15;

endpackage

// File: rtl/rst_sync_2ff.sv
// rst_sync_2ff: asynchronous-assert, synchronous-deassert reset synchronizer.
// The output rises immediately with rst1 and falls on the second clock0 edge
// after rst1 is released, so downstream flops never see a release that races
// the clock.
module rst_sync_2ff (
  input  logic clock0,
  input  logic rst1,
  output logic rst_sync_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift of the deasserted level; both stages preset by rst1.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both stages sample their inputs
      // before either updates, so the level really takes two edges to pass.
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_o = sync_q;

endmodule

// File: rtl/hop_rst_seq.sv
// hop_rst_seq: after the global reset (or a software re-sequence request) it
// releases the per-stage resets of a hop chain lowest index first, spaced
// HOLD_CYC cycles apart. Once the chain is up, each go_i launches one start
// token and the cycles until it comes back on ff5_i are measured and judged
// against EXP_LAT. Any token seen outside a measurement is flagged sticky.
module hop_rst_seq
  import hop_pkg::*;
#(
  parameter int NUM_RST  = 3,
  parameter int HOLD_CYC = HOP_HOLD_CYC,
  parameter int EXP_LAT  = HOP_EXP_LAT,
  parameter int TIMEOUT  = HOP_TIMEOUT,
  parameter int CNT_W    = 4
) (
  input  logic               clock0,
  input  logic               rst1,
  input  logic               sw_rst_i,
  input  logic               go_i,
  input  logic               ff5_i,
  output logic [NUM_RST-1:0] rst_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   lat_o
);

  // Counter values the comparisons need, sized to the counters.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXP_V     = CNT_W'(EXP_LAT);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  // Synchronized global reset: asserts with rst1, releases on the 2nd edge.
  logic rst_sync;

  hop_seq_state_t     state_q,   state_d;
  logic [CNT_W-1:0]   hold_q,    hold_d;     // cycles since the last release step
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;  // cycles since launch
  logic [NUM_RST-1:0] rst_q,     rst_d;
  logic               start_q,   start_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               pass_q,    pass_d;
  logic               err_q,     err_d;
  logic [CNT_W-1:0]   lat_q,     lat_d;

  // Scratch values derived from the current state inside the comb process.
  logic [NUM_RST-1:0] rst_next;
  logic [CNT_W-1:0]   lat_next;

  rst_sync_2ff u_rst_sync (
    .clock0     (clock0),
    .rst1       (rst1),
    .rst_sync_o (rst_sync)
  );

  // State and output registers; everything returns to the held-reset values
  // the moment rst1 rises.
  always_ff @(posedge clock0 or posedge rst_sync) begin
    if (rst_sync) begin
      state_q   <= RST_HOLD;
      hold_q    <= '0;
      lat_cnt_q <= '0;
      rst_q     <= '1;
      start_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 1'b0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      lat_cnt_q <= lat_cnt_d;
      rst_q     <= rst_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      lat_q     <= lat_d;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so paths that do
    // not mention it hold the register instead of inferring a latch.
    state_d   = state_q;
    hold_d    = hold_q;
    lat_cnt_d = lat_cnt_q;
    rst_d     = rst_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    lat_d     = lat_q;
    // A returning token is only legitimate while a measurement is running.
    err_d     = err_q | (ff5_i && (state_q != WAIT));
    // Clearing the lowest still-asserted bit of a thermometer code.
    rst_next  = rst_q << 1;
    lat_next  = lat_cnt_q + 1'b1;

    if (sw_rst_i) begin
      // Software re-sequence overrides everything, including a same-cycle go.
      state_d   = RELEASE;
      hold_d    = '0;
      lat_cnt_d = '0;
      rst_d     = '1;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      err_d     = 1'b0;
      lat_d     = '0;
    end else begin
      case (state_q)
        // RST_HOLD is only ever clocked once the synchronizer has released,
        // and that release edge already counts as hold cycle 0, so it runs
        // the same stepping as RELEASE.
        RST_HOLD, RELEASE: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            rst_d  = rst_next;
            if (rst_next == '0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hold_d  = hold_q + 1'b1;
            state_d = RELEASE;
          end
        end

        IDLE, DONE: begin
          if (go_i) begin
            state_d   = WAIT;
            start_d   = 1'b1;
            lat_cnt_d = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
          end
        end

        WAIT: begin
          if (ff5_i) begin
            state_d = DONE;
            lat_d   = lat_next;
            pass_d  = (lat_next == EXP_V);
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (lat_next == TIMEOUT_V) begin
            state_d = DONE;
            lat_d   = TIMEOUT_V;
            pass_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            lat_cnt_d = lat_next;
          end
        end

        default: begin
          state_d = RST_HOLD;
        end
      endcase
    end
  end

  assign rst_o   = rst_q;
  assign start_o = start_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign pass_o  = pass_q;
  assign err_o   = err_q;
  assign lat_o   = lat_q;

endmodule

// File: tb/tb_hop_rst_seq.sv
// Bench for hop_rst_seq. The hop chain is modelled as a delay line that
// replays start_o on ff5_i a chosen number of cycles later; expected results
// come from the release/latency rules written as plain arithmetic.
module tb_hop_rst_seq;

  localparam int NUM_RST  = 3;
  localparam int HOLD_CYC = 4;
  localparam int EXP_LAT  = 5;
  localparam int TIMEOUT  = 15;
  localparam int CNT_W    = 4;

  logic               clock0;
  logic               rst1;
  logic               sw_rst_i;
  logic               go_i;
  logic               ff5_i;
  logic [NUM_RST-1:0] rst_o;
  logic               start_o;
  logic               busy_o;
  logic               done_o;
  logic               pass_o;
  logic               err_o;
  logic [CNT_W-1:0]   lat_o;

  // Chain model: hist[i] is start_o as seen i+1 cycles ago.
  logic [31:0] hist;
  int          chain_delay;  // 0 = chain output tied low
  logic        ff5_force;    // stray pulse injected by the bench
  bit          err_exp;      // model of the sticky error flag

  int n_total;
  int n_pass;

  assign ff5_i = ff5_force | ((chain_delay > 0) ? hist[chain_delay-1] : 1'b0);

  hop_rst_seq #(
    .NUM_RST  (NUM_RST),
    .HOLD_CYC (HOLD_CYC),
    .EXP_LAT  (EXP_LAT),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clock0   (clock0),
    .rst1     (rst1),
    .sw_rst_i (sw_rst_i),
    .go_i     (go_i),
    .ff5_i    (ff5_i),
    .rst_o    (rst_o),
    .start_o  (start_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .pass_o   (pass_o),
    .err_o    (err_o),
    .lat_o    (lat_o)
  );

  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  // One active edge; outputs are then observed on the falling edge and the
  // chain delay line advances.
  task automatic step();
    @(posedge clock0);
    @(negedge clock0);
    hist = {hist[30:0], start_o};
  endtask

  // Release sequence seen from edge j=first onward, where stage k is expected
  // to drop at edge base+(k+1)*HOLD_CYC and busy_o with the last stage.
  task automatic expect_release(input string tag, input int base, input int first,
                                input bit go_noise);
    logic [NUM_RST-1:0] exp_rst;
    int last;
    last = base + NUM_RST * HOLD_CYC;
    for (int j = first; j <= last + 1; j++) begin
      go_i = (go_noise && j <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      go_i = 1'b0;
      for (int k = 0; k < NUM_RST; k++) exp_rst[k] = (j < base + (k + 1) * HOLD_CYC);
      n_total++;
      if (rst_o !== exp_rst)
        $display("FAIL %s rst_o@%0d: got %b expected %b", tag, j, rst_o, exp_rst);
      else n_pass++;
      n_total++;
      if (busy_o !== 1'(j < last))
        $display("FAIL %s busy_o@%0d: got %b expected %b", tag, j, busy_o, j < last);
      else n_pass++;
      n_total++;
      if ({start_o, done_o} !== 2'b00)
        $display("FAIL %s start_o/done_o@%0d: got %b%b expected 00", tag, j, start_o, done_o);
      else n_pass++;
    end
  endtask

  // One launch with the chain delay d (0 = no return); checks the pulse, the
  // quiet WAIT period, and the latched result.
  task automatic measure(input string tag, input int d);
    int exp_lat;
    logic [CNT_W-1:0] exp_lat_v;
    exp_lat   = (d >= 1 && d <= TIMEOUT) ? d : TIMEOUT;
    exp_lat_v = exp_lat[CNT_W-1:0];
    chain_delay = d;
    hist = '0;
    go_i = 1'b1;
    step();
    go_i = 1'b0;
    n_total++;
    if ({start_o, busy_o, done_o} !== 3'b110)
      $display("FAIL %s launch start/busy/done: got %b%b%b expected 110", tag, start_o, busy_o, done_o);
    else n_pass++;
    for (int k = 1; k <= exp_lat; k++) begin
      go_i = 1'($urandom_range(0, 1));  // must be ignored while waiting
      step();
      go_i = 1'b0;
      n_total++;
      if (start_o !== 1'b0)
        $display("FAIL %s start_o@+%0d: got %b expected 0", tag, k, start_o);
      else n_pass++;
      n_total++;
      if (done_o !== 1'(k == exp_lat))
        $display("FAIL %s done_o@+%0d: got %b expected %b", tag, k, done_o, k == exp_lat);
      else n_pass++;
    end
    n_total++;
    if (lat_o !== exp_lat_v)
      $display("FAIL %s lat_o: got %0d expected %0d", tag, lat_o, exp_lat);
    else n_pass++;
    n_total++;
    if (pass_o !== 1'(exp_lat == EXP_LAT))
      $display("FAIL %s pass_o: got %b expected %b", tag, pass_o, exp_lat == EXP_LAT);
    else n_pass++;
    n_total++;
    if (busy_o !== 1'b0)
      $display("FAIL %s busy_o after done: got %b expected 0", tag, busy_o);
    else n_pass++;
    n_total++;
    if (err_o !== err_exp)
      $display("FAIL %s err_o: got %b expected %b", tag, err_o, err_exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    repeat (2) step();
    n_total++;
    if ({rst_o, start_o, busy_o, done_o, pass_o, err_o} !== {{NUM_RST{1'b1}}, 5'b01000})
      $display("FAIL reset outputs: got %b_%b%b%b%b%b expected 111_01000",
               rst_o, start_o, busy_o, done_o, pass_o, err_o);
    else n_pass++;
    n_total++;
    if (lat_o !== '0) $display("FAIL reset lat_o: got %0d expected 0", lat_o);
    else n_pass++;
    rst1 = 1'b0;
    expect_release("reset_release", 2, 1, 1'b0);
  endtask

  task automatic test_loopback();
    measure("loop5", EXP_LAT);
    step();
    n_total++;
    if ({done_o, start_o, lat_o} !== {2'b10, 4'(EXP_LAT)})
      $display("FAIL loop5 hold: got done=%b start=%b lat=%0d expected 1 0 %0d",
               done_o, start_o, lat_o, EXP_LAT);
    else n_pass++;
  endtask

  task automatic test_timeout();
    measure("timeout", 0);
  endtask

  task automatic test_back_to_back();
    measure("short4", 4);
    measure("relaunch5", 5);
  endtask

  task automatic test_random_loopback();
    for (int t = 0; t < 8; t++) begin
      int d;
      int gap;
      d   = $urandom_range(1, TIMEOUT);
      gap = $urandom_range(0, 3);
      measure($sformatf("rand%0d_d%0d", t, d), d);
      chain_delay = 0;
      repeat (gap) begin
        step();
        n_total++;
        if (done_o !== 1'b1 || start_o !== 1'b0)
          $display("FAIL rand%0d idle hold: got done=%b start=%b expected 1 0", t, done_o, start_o);
        else n_pass++;
      end
    end
  endtask

  task automatic test_err_sticky();
    chain_delay = 0;
    hist = '0;
    ff5_force = 1'b1;
    step();
    ff5_force = 1'b0;
    err_exp = 1'b1;
    n_total++;
    if (err_o !== 1'b1) $display("FAIL stray err_o: got %b expected 1", err_o);
    else n_pass++;
    measure("err_meas", EXP_LAT);
    // Re-sequence with a simultaneous go: the re-sequence must win.
    sw_rst_i = 1'b1;
    go_i = 1'b1;
    step();
    sw_rst_i = 1'b0;
    go_i = 1'b0;
    err_exp = 1'b0;
    n_total++;
    if ({rst_o, start_o, busy_o, done_o, err_o} !== {{NUM_RST{1'b1}}, 4'b0100})
      $display("FAIL swrst_err outputs: got %b_%b%b%b%b expected 111_0100",
               rst_o, start_o, busy_o, done_o, err_o);
    else n_pass++;
    expect_release("swrst_err_release", 0, 1, 1'b1);
    n_total++;
    if (err_o !== 1'b0) $display("FAIL swrst_err err_o after release: got %b expected 0", err_o);
    else n_pass++;
  endtask

  task automatic test_sw_rst_wait();
    int off;
    off = $urandom_range(1, TIMEOUT - 1);
    chain_delay = 0;
    hist = '0;
    go_i = 1'b1;
    step();
    go_i = 1'b0;
    repeat (off - 1) step();
    sw_rst_i = 1'b1;
    step();
    sw_rst_i = 1'b0;
    n_total++;
    if ({rst_o, start_o, busy_o, done_o, pass_o, err_o} !== {{NUM_RST{1'b1}}, 5'b01000})
      $display("FAIL swrst_wait outputs: got %b_%b%b%b%b%b expected 111_01000",
               rst_o, start_o, busy_o, done_o, pass_o, err_o);
    else n_pass++;
    n_total++;
    if (lat_o !== '0) $display("FAIL swrst_wait lat_o: got %0d expected 0", lat_o);
    else n_pass++;
    expect_release("swrst_wait_release", 0, 1, 1'b1);
    measure("after_swrst", EXP_LAT);
  endtask

  task automatic test_async_reset();
    measure("pre_async", 4);
    #2;
    rst1 = 1'b1;
    #1;
    n_total++;
    if ({rst_o, busy_o, done_o, pass_o, lat_o} !== {{NUM_RST{1'b1}}, 3'b100, 4'd0})
      $display("FAIL async assert: got rst=%b busy=%b done=%b pass=%b lat=%0d expected 111 1 0 0 0",
               rst_o, busy_o, done_o, pass_o, lat_o);
    else n_pass++;
    step();
    rst1 = 1'b0;
    expect_release("async_release", 2, 1, 1'b0);
  endtask

  initial begin
    rst1        = 1'b1;
    sw_rst_i    = 1'b0;
    go_i        = 1'b0;
    ff5_force   = 1'b0;
    chain_delay = 0;
    hist        = '0;
    err_exp     = 1'b0;
    n_total     = 0;
    n_pass      = 0;

    test_reset();
    test_loopback();
    test_timeout();
    test_back_to_back();
    test_random_loopback();
    test_err_sticky();
    test_sw_rst_wait();
    test_async_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hop_rst_seq.md
# hop_rst_seq

Reset-release sequencer and loopback latency checker for the hop-chain benchmarks. It drives the per-stage resets of a hop chain (rst2..rst4) and releases them in a staggered, synchronous order after the global reset. It then launches a single start token into the chain and times its return on ff5. It reports measured latency, pass/fail against the expected hop count, and any spurious return.

## Interface
Parameters:
- NUM_RST, 3, number of downstream stage resets driven; rst_o[0] feeds rst2, rst_o[NUM_RST-1] feeds the last stage
- HOLD_CYC, 4, clock0 cycles between successive reset releases (≥1)
- EXP_LAT, 5, expected cycles from start_o high to ff5_i high
- TIMEOUT, 15, cycles after launch before declaring loss (> EXP_LAT)
- CNT_W, 4, width of latency/hold counters; must hold max(TIMEOUT, HOLD_CYC)

Ports:
- clock0  in  1  clock
- rst1  in  1  reset rst1, asynchronous, active-high; clock clock0
- sw_rst_i  in  1  synchronous re-sequence request
- go_i  in  1  launch request
- ff5_i  in  1  token return from chain output
- rst_o  out  NUM_RST  stage resets, active-high
- start_o  out  1  token pulse into chain
- busy_o  out  1  reset sequence or measurement in progress
- done_o  out  1  measurement complete, held until next launch or reset
- pass_o  out  1  lat_o == EXP_LAT; valid when done_o=1
- err_o  out  1  sticky: ff5_i high while not in WAIT
- lat_o  out  CNT_W  measured latency

## Operation
- States: RST_HOLD, RELEASE, IDLE, WAIT, DONE.
- rst1 high (async): all rst_o=1, start_o=0, busy_o=1, done_o/pass_o/err_o=0, lat_o=0, state RST_HOLD.
- rst1 deassertion passes through a 2-flop synchronizer. The FSM leaves RST_HOLD on the 2nd clock0 edge after release and enters RELEASE with hold counter = 0.
- RELEASE: rst_o[k] drops after (k+1)·HOLD_CYC counted cycles, lowest index first. The drops are monotonic; a released bit never re-asserts except via rst1 or sw_rst_i. On the edge rst_o[NUM_RST-1] drops: go to IDLE and busy_o=0.
- IDLE/DONE + go_i=1: start_o=1 for exactly one cycle; lat counter=0; done_o=0; busy_o=1; go to WAIT.
- WAIT: the counter increments each cycle.
  - ff5_i=1 at count c: lat_o=c, pass_o=(c==EXP_LAT), done_o=1, go to DONE.
  - Count reaches TIMEOUT: lat_o=TIMEOUT, pass_o=0, done_o=1, go to DONE.
- go_i in RST_HOLD, RELEASE, or WAIT is ignored (not queued).
- ff5_i=1 in any state other than WAIT sets err_o. err_o clears only on rst1 or sw_rst_i.
- sw_rst_i sampled high in any state:
  - At that edge: all rst_o=1, start_o=0, done_o/pass_o/err_o/lat_o cleared, busy_o=1.
  - Enter RELEASE with the counter cleared. No synchronizer delay, because the request is already synchronous.
- sw_rst_i and go_i high together: sw_rst_i wins.
- Mid-sequence sw_rst_i restarts the full release order from rst_o[0].

## Timing
- rst1 falls before edge 1: rst_o[k] drops at edge 2+(k+1)·HOLD_CYC. Defaults give edges 6, 10, 14. busy_o falls at edge 14.
- sw_rst_i sampled at edge E: rst_o[k] drops at E+(k+1)·HOLD_CYC.
- go_i sampled at edge G: start_o high during cycle G..G+1, which is count 0.
- ff5_i sampled high at edge G+n gives lat_o=n. done_o, pass_o, and lat_o update on that same edge. For a 5-flop chain n=5.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package hop_pkg:
  - state enum hop_seq_state_t
  - default constants HOP_EXP_LAT=5 and HOP_HOLD_CYC=4, shared with the other hopN benchmarks
- Sub-module rst_sync_2ff: async-assert, sync-deassert synchronizer for rst1. It is reused by the other hop designs.
- The remainder is a single FSM plus a hold counter and a latency counter.

## Test plan
- rst1 pulse, release before edge 1, defaults → rst_o = 111, then 110@6, 100@10, 000@14; busy_o 0 from edge 14.
- IDLE, go_i at edge G, ff5_i modeled as start_o delayed 5 cycles → start_o one cycle wide, done_o=1, lat_o=5, pass_o=1 at edge G+5.
- ff5_i tied 0, go_i → done_o=1 and lat_o=15 at edge G+15, pass_o=0.
- ff5_i delayed 4 cycles → lat_o=4, pass_o=0. Then a second go_i from DONE with 5-cycle delay → lat_o=5, pass_o=1, err_o=0.
- ff5_i pulse while IDLE → err_o=1 and stays 1 across a following go/measurement. sw_rst_i clears it and restarts the release sequence.
- sw_rst_i at edge E during WAIT → rst_o=111 at E, no done_o; release edges E+4/E+8/E+12; go_i during RELEASE ignored.
